// File: rtl/dsram_arb.sv
// Two-master round-robin arbiter and access sequencer for the data SRAM.
// One access per cycle, single pending-response slot, aligned/extended load data.
module dsram_arb #(
  parameter int AW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_req_valid_i,
  output logic          m0_req_ready_o,
  input  logic          m0_req_we_i,
  input  logic [AW+1:0] m0_req_addr_i,
  input  logic [1:0]    m0_req_size_i,
  input  logic          m0_req_unsigned_i,
  input  logic [31:0]   m0_req_wdata_i,
  output logic          m0_rsp_valid_o,
  input  logic          m0_rsp_ready_i,
  output logic [31:0]   m0_rsp_rdata_o,
  output logic          m0_rsp_err_o,
  input  logic          m1_req_valid_i,
  output logic          m1_req_ready_o,
  input  logic          m1_req_we_i,
  input  logic [AW+1:0] m1_req_addr_i,
  input  logic [1:0]    m1_req_size_i,
  input  logic          m1_req_unsigned_i,
  input  logic [31:0]   m1_req_wdata_i,
  output logic          m1_rsp_valid_o,
  input  logic          m1_rsp_ready_i,
  output logic [31:0]   m1_rsp_rdata_o,
  output logic          m1_rsp_err_o,
  output logic          sram_csn_o,
  output logic          sram_wen_o,
  output logic [3:0]    sram_ben_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [31:0]   sram_din_o,
  input  logic [31:0]   sram_dout_i
);

  function automatic logic req_err(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'd0:    req_err = 1'b0;
      2'd1:    req_err = lsb[0];
      2'd2:    req_err = (lsb != 2'd0);
      default: req_err = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] size_ben(input logic [1:0] size);
    case (size)
      2'd0:    size_ben = 4'b0001;
      2'd1:    size_ben = 4'b0011;
      2'd2:    size_ben = 4'b1111;
      default: size_ben = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'd0:    load_ext = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'd1:    load_ext = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      2'd2:    load_ext = sh;
      default: load_ext = 32'h00000000;
    endcase
  endfunction

  logic       pend_valid_q, pend_valid_d;
  logic       pend_owner_q, pend_owner_d;
  logic       pend_load_q, pend_load_d;
  logic       pend_err_q, pend_err_d;
  logic [1:0] pend_off_q, pend_off_d;
  logic [1:0] pend_size_q, pend_size_d;
  logic       pend_uns_q, pend_uns_d;
  logic       rr_ptr_q, rr_ptr_d;

  logic          own_rsp_ready_s;
  logic          can_issue_s;
  logic          grant_s;
  logic          accept_s;
  logic          access_s;
  logic          g_we_s;
  logic [AW+1:0] g_addr_s;
  logic [1:0]    g_size_s;
  logic          g_uns_s;
  logic [31:0]   g_wdata_s;
  logic          g_err_s;
  logic [31:0]   rsp_data_s;

  // Grant selection and the request mux; ready only when the slot can be refilled.
  always_comb begin
    own_rsp_ready_s = pend_owner_q ? m1_rsp_ready_i : m0_rsp_ready_i;
    can_issue_s     = !pend_valid_q || own_rsp_ready_s;
    if (m0_req_valid_i && m1_req_valid_i) begin
      grant_s = rr_ptr_q;
    end else begin
      grant_s = m1_req_valid_i;
    end
    accept_s = (m0_req_valid_i || m1_req_valid_i) && can_issue_s && !rst_i;
    if (grant_s) begin
      g_we_s    = m1_req_we_i;
      g_addr_s  = m1_req_addr_i;
      g_size_s  = m1_req_size_i;
      g_uns_s   = m1_req_unsigned_i;
      g_wdata_s = m1_req_wdata_i;
    end else begin
      g_we_s    = m0_req_we_i;
      g_addr_s  = m0_req_addr_i;
      g_size_s  = m0_req_size_i;
      g_uns_s   = m0_req_unsigned_i;
      g_wdata_s = m0_req_wdata_i;
    end
    g_err_s  = req_err(g_size_s, g_addr_s[1:0]);
    access_s = accept_s && !g_err_s;
  end

  assign m0_req_ready_o = can_issue_s && !grant_s && !rst_i;
  assign m1_req_ready_o = can_issue_s && grant_s && !rst_i;

  // SRAM strobes are only active in the cycle a legal request is accepted.
  always_comb begin
    sram_csn_o  = !access_s;
    sram_wen_o  = !(access_s && g_we_s);
    sram_addr_o = g_addr_s[AW+1:2];
    sram_din_o  = g_wdata_s << {g_addr_s[1:0], 3'b000};
    if (access_s) begin
      sram_ben_o = size_ben(g_size_s) << g_addr_s[1:0];
    end else begin
      sram_ben_o = 4'b0000;
    end
  end

  // Pending slot: reload on accept, otherwise drain on the owner's handshake.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_owner_d = pend_owner_q;
    pend_load_d  = pend_load_q;
    pend_err_d   = pend_err_q;
    pend_off_d   = pend_off_q;
    pend_size_d  = pend_size_q;
    pend_uns_d   = pend_uns_q;
    rr_ptr_d     = rr_ptr_q;
    if (accept_s) begin
      pend_valid_d = 1'b1;
      pend_owner_d = grant_s;
      pend_load_d  = !g_we_s;
      pend_err_d   = g_err_s;
      pend_off_d   = g_addr_s[1:0];
      pend_size_d  = g_size_s;
      pend_uns_d   = g_uns_s;
      rr_ptr_d     = !grant_s;
    end else if (pend_valid_q && own_rsp_ready_s) begin
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_valid_q <= 1'b0;
      pend_owner_q <= 1'b0;
      pend_load_q  <= 1'b0;
      pend_err_q   <= 1'b0;
      pend_off_q   <= 2'd0;
      pend_size_q  <= 2'd0;
      pend_uns_q   <= 1'b0;
      rr_ptr_q     <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_owner_q <= pend_owner_d;
      pend_load_q  <= pend_load_d;
      pend_err_q   <= pend_err_d;
      pend_off_q   <= pend_off_d;
      pend_size_q  <= pend_size_d;
      pend_uns_q   <= pend_uns_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  // Read data comes straight off the SRAM; it stays valid because csn holds high while stalled.
  always_comb begin
    if (pend_load_q && !pend_err_q) begin
      rsp_data_s = load_ext(sram_dout_i, pend_off_q, pend_size_q, pend_uns_q);
    end else begin
      rsp_data_s = 32'h00000000;
    end
    m0_rsp_valid_o = pend_valid_q && !pend_owner_q;
    m1_rsp_valid_o = pend_valid_q && pend_owner_q;
    m0_rsp_rdata_o = m0_rsp_valid_o ? rsp_data_s : 32'h00000000;
    m1_rsp_rdata_o = m1_rsp_valid_o ? rsp_data_s : 32'h00000000;
    m0_rsp_err_o   = m0_rsp_valid_o && pend_err_q;
    m1_rsp_err_o   = m1_rsp_valid_o && pend_err_q;
  end

endmodule

// File: tb/tb_dsram_arb.sv
// Self-checking bench for dsram_arb: directed scenarios plus randomized traffic,
// with a byte-level reference memory and per-master response scoreboards.
module tb_dsram_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_we, req_uns, rsp_ready;
  logic [1:0][17:0] req_addr;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_wdata;

  wire        m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err;
  wire [31:0] m0_rsp_rdata, m1_rsp_rdata;
  wire        sram_csn, sram_wen;
  wire [3:0]  sram_ben;
  wire [15:0] sram_addr;
  wire [31:0] sram_din;
  wire [31:0] sram_dout;

  dsram_arb #(.AW(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_valid_i(req_valid[0]), .m0_req_ready_o(m0_req_ready), .m0_req_we_i(req_we[0]),
    .m0_req_addr_i(req_addr[0]), .m0_req_size_i(req_size[0]), .m0_req_unsigned_i(req_uns[0]),
    .m0_req_wdata_i(req_wdata[0]), .m0_rsp_valid_o(m0_rsp_valid), .m0_rsp_ready_i(rsp_ready[0]),
    .m0_rsp_rdata_o(m0_rsp_rdata), .m0_rsp_err_o(m0_rsp_err),
    .m1_req_valid_i(req_valid[1]), .m1_req_ready_o(m1_req_ready), .m1_req_we_i(req_we[1]),
    .m1_req_addr_i(req_addr[1]), .m1_req_size_i(req_size[1]), .m1_req_unsigned_i(req_uns[1]),
    .m1_req_wdata_i(req_wdata[1]), .m1_rsp_valid_o(m1_rsp_valid), .m1_rsp_ready_i(rsp_ready[1]),
    .m1_rsp_rdata_o(m1_rsp_rdata), .m1_rsp_err_o(m1_rsp_err),
    .sram_csn_o(sram_csn), .sram_wen_o(sram_wen), .sram_ben_o(sram_ben),
    .sram_addr_o(sram_addr), .sram_din_o(sram_din), .sram_dout_i(sram_dout)
  );

  // Synchronous SRAM: writes and address latch on a csn-low edge.
  logic [31:0] sram_mem [0:63];
  logic [5:0]  lat_addr = 6'd0;
  assign sram_dout = sram_mem[lat_addr];
  always @(posedge clk) begin
    if (!sram_csn) begin
      for (int b = 0; b < 4; b++)
        if (!sram_wen && sram_ben[b]) sram_mem[sram_addr[5:0]][8*b +: 8] <= sram_din[8*b +: 8];
      lat_addr <= sram_addr[5:0];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte memory, pending owner, round-robin favourite.
  logic [7:0]  ref_mem [0:255];
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  bit          mp_valid = 1'b0, mp_owner = 1'b0, m_rr = 1'b0;
  bit          busy, win, acc, mv, me, err;
  logic [1:0]  exp_rdy;
  logic [31:0] md;
  logic [32:0] fr;
  logic [3:0]  eben;
  int          a, nb, qs, sz;
  longint      val;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", {30'd0, m1_req_ready, m0_req_ready}, 32'd0);
      chk("rst_rsp_valid", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
      chk("rst_sram_idle", {26'd0, sram_csn, sram_wen, sram_ben}, {26'd0, 1'b1, 1'b1, 4'b0000});
      q0.delete();
      q1.delete();
      mp_valid = 1'b0;
      mp_owner = 1'b0;
      m_rr     = 1'b0;
    end else begin
      busy    = mp_valid && !rsp_ready[mp_owner];
      win     = (req_valid == 2'b11) ? m_rr : req_valid[1];
      exp_rdy = busy ? 2'b00 : (win ? 2'b10 : 2'b01);
      chk("req_ready", {30'd0, m1_req_ready, m0_req_ready}, {30'd0, exp_rdy});
      for (int n = 0; n < 2; n++) begin
        mv = (n == 0) ? m0_rsp_valid : m1_rsp_valid;
        md = (n == 0) ? m0_rsp_rdata : m1_rsp_rdata;
        me = (n == 0) ? m0_rsp_err : m1_rsp_err;
        chk("rsp_valid", {31'd0, mv}, {31'd0, mp_valid && (mp_owner == n[0])});
        if (mv) begin
          qs = (n == 0) ? q0.size() : q1.size();
          if (qs == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
          end else begin
            fr = (n == 0) ? q0[0] : q1[0];
            chk("rsp_rdata", md, fr[31:0]);
            chk("rsp_err", {31'd0, me}, {31'd0, fr[32]});
            if (rsp_ready[n]) begin
              if (n == 0) void'(q0.pop_front());
              else        void'(q1.pop_front());
            end
          end
        end else begin
          chk("rsp_idle_rdata", md, 32'd0);
          chk("rsp_idle_err", {31'd0, me}, 32'd0);
        end
      end
      acc = |(exp_rdy & req_valid);
      if (acc) begin
        a   = int'(req_addr[win]);
        sz  = int'(req_size[win]);
        nb  = 1 << sz;
        err = (sz == 3) || ((a % nb) != 0);
        if (err) begin
          chk("err_no_csn", {31'd0, sram_csn}, 32'd1);
          fr = {1'b1, 32'd0};
        end else begin
          chk("sram_csn", {31'd0, sram_csn}, 32'd0);
          chk("sram_wen", {31'd0, sram_wen}, {31'd0, !req_we[win]});
          chk("sram_addr", 32'(sram_addr), 32'(a >> 2));
          eben = 4'b0000;
          for (int i = 0; i < nb; i++) eben[(a % 4) + i] = 1'b1;
          chk("sram_ben", {28'd0, sram_ben}, {28'd0, eben});
          val = 0;
          for (int i = 0; i < nb; i++) begin
            if (req_we[win]) begin
              chk("sram_din", {24'd0, sram_din[8*((a % 4) + i) +: 8]}, {24'd0, req_wdata[win][8*i +: 8]});
              ref_mem[a + i] = req_wdata[win][8*i +: 8];
            end else begin
              val = val | (longint'(ref_mem[a + i]) << (8 * i));
            end
          end
          if (!req_we[win] && !req_uns[win] && val[8*nb-1]) val = val - (longint'(1) << (8 * nb));
          fr = {1'b0, req_we[win] ? 32'd0 : val[31:0]};
        end
        if (win) q1.push_back(fr);
        else     q0.push_back(fr);
        mp_valid = 1'b1;
        mp_owner = win;
        m_rr     = !win;
      end else begin
        chk("sram_idle", {26'd0, sram_csn, sram_wen, sram_ben}, {26'd0, 1'b1, 1'b1, 4'b0000});
        if (mp_valid && rsp_ready[mp_owner]) mp_valid = 1'b0;
      end
    end
  end

  task automatic set_req(input int n, input logic v, input logic we, input logic [17:0] ad,
                         input logic [1:0] sz_i, input logic u, input logic [31:0] wd);
    req_valid[n] = v;
    req_we[n]    = we;
    req_addr[n]  = ad;
    req_size[n]  = sz_i;
    req_uns[n]   = u;
    req_wdata[n] = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) sram_mem[i] = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
    set_req(0, 1'b0, 1'b0, 18'd0, 2'd0, 1'b0, 32'd0);
    set_req(1, 1'b0, 1'b0, 18'd0, 2'd0, 1'b0, 32'd0);
    rsp_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Word store, then byte loads with sign extension.
    set_req(0, 1'b1, 1'b1, 18'h00010, 2'd2, 1'b0, 32'h11223344);
    @(negedge clk);
    chk("t1_csn", {31'd0, sram_csn}, 32'd0);
    chk("t1_wen", {31'd0, sram_wen}, 32'd0);
    chk("t1_ben", {28'd0, sram_ben}, 32'h0000000f);
    chk("t1_addr", {16'd0, sram_addr}, 32'h00000004);
    chk("t1_din", sram_din, 32'h11223344);
    next_cycle();
    set_req(0, 1'b0, 1'b0, 18'd0, 2'd0, 1'b0, 32'd0);
    set_req(1, 1'b1, 1'b0, 18'h00013, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("t1_rsp", {m0_rsp_valid, m0_rsp_err, 30'd0}, {1'b1, 1'b0, 30'd0});
    chk("t1_rdata", m0_rsp_rdata, 32'd0);
    next_cycle();
    set_req(1, 1'b0, 1'b0, 18'd0, 2'd0, 1'b0, 32'd0);
    set_req(0, 1'b1, 1'b1, 18'h00012, 2'd0, 1'b0, 32'h00000080);
    @(negedge clk);
    chk("t2_rdata", m1_rsp_rdata, 32'h00000011);
    chk("t2_ben", {28'd0, sram_ben}, 32'h00000004);
    next_cycle();
    set_req(0, 1'b0, 1'b0, 18'd0, 2'd0, 1'b0, 32'd0);
    set_req(1, 1'b1, 1'b0, 18'h00012, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    next_cycle();
    set_req(1, 1'b0, 1'b0, 18'd0, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("t2_sext", m1_rsp_rdata, 32'hffffff80);

    // Both masters requesting: grants alternate starting with m0.
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      set_req(0, 1'b1, 1'b0, 18'(4 * k), 2'd2, 1'b1, 32'd0);
      set_req(1, 1'b1, 1'b0, 18'(4 * k + 32), 2'd2, 1'b1, 32'd0);
      @(negedge clk);
      chk("alt_grant", {30'd0, m1_req_ready, m0_req_ready}, (k % 2 == 1) ? 32'd2 : 32'd1);
      chk("alt_csn", {31'd0, sram_csn}, 32'd0);
    end

    // Stalled m0 load blocks m1 until rsp_ready rises.
    next_cycle();
    set_req(0, 1'b1, 1'b0, 18'h00010, 2'd2, 1'b1, 32'd0);
    set_req(1, 1'b0, 1'b0, 18'd0, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("stall_issue", {31'd0, m0_req_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      set_req(0, 1'b0, 1'b0, 18'd0, 2'd0, 1'b0, 32'd0);
      set_req(1, 1'b1, 1'b0, 18'h00004, 2'd2, 1'b1, 32'd0);
      rsp_ready = 2'b10;
      @(negedge clk);
      chk("stall_rdata", m0_rsp_rdata, 32'h11803344);
      chk("stall_m1_ready", {30'd0, m1_req_ready, sram_csn}, 32'd1);
    end
    next_cycle();
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("stall_release", {30'd0, m1_req_ready, sram_csn}, 32'd2);

    // Misaligned half store and illegal size: no SRAM access, err responses.
    next_cycle();
    set_req(0, 1'b1, 1'b1, 18'h00021, 2'd1, 1'b0, 32'h0000beef);
    set_req(1, 1'b1, 1'b0, 18'h00008, 2'd3, 1'b0, 32'd0);
    @(negedge clk);
    chk("err0_issue", {30'd0, m0_req_ready, sram_csn}, 32'd3);
    next_cycle();
    set_req(0, 1'b0, 1'b0, 18'd0, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("err1_issue", {30'd0, m1_req_ready, sram_csn}, 32'd3);
    chk("err0_rsp", {m0_rsp_err, m0_rsp_rdata[30:0]}, 32'h80000000);
    next_cycle();
    set_req(1, 1'b0, 1'b0, 18'd0, 2'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("err1_rsp", {m1_rsp_err, m1_rsp_rdata[30:0]}, 32'h80000000);

    // Reset while an m1 load response is stalled.
    next_cycle();
    set_req(1, 1'b1, 1'b0, 18'h00010, 2'd2, 1'b1, 32'd0);
    @(negedge clk);
    next_cycle();
    set_req(1, 1'b0, 1'b0, 18'd0, 2'd0, 1'b0, 32'd0);
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("rst_pre_valid", {31'd0, m1_rsp_valid}, 32'd1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drop_valid", {31'd0, m1_rsp_valid}, 32'd0);
    next_cycle();
    rst = 1'b0;
    rsp_ready = 2'b11;
    set_req(0, 1'b1, 1'b0, 18'h00000, 2'd2, 1'b1, 32'd0);
    set_req(1, 1'b1, 1'b0, 18'h00004, 2'd2, 1'b1, 32'd0);
    @(negedge clk);
    chk("rst_first_grant", {30'd0, m1_req_ready, m0_req_ready}, 32'd1);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      for (int n = 0; n < 2; n++) begin
        int r, s, ad;
        r  = $urandom_range(0, 7);
        s  = (r < 2) ? 0 : (r < 4) ? 1 : (r < 7) ? 2 : 3;
        ad = $urandom_range(0, 255);
        if ($urandom_range(0, 3) != 0 && s < 3) ad = ad & ~((1 << s) - 1);
        set_req(n, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 18'(ad), 2'(s),
                1'($urandom_range(0, 1)), $urandom);
        rsp_ready[n] = ($urandom_range(0, 3) != 0);
      end
    end

    next_cycle();
    set_req(0, 1'b0, 1'b0, 18'd0, 2'd0, 1'b0, 32'd0);
    set_req(1, 1'b0, 1'b0, 18'd0, 2'd0, 1'b0, 32'd0);
    rsp_ready = 2'b11;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("drain_q", 32'(q0.size() + q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dsram_arb.md
# dsram_arb

Two-master arbiter and access sequencer for the data SRAM. It accepts byte-addressed load/store requests from two requesters over valid/ready handshakes: master 0 is the core load/store unit and master 1 is the debug/DMA port. It grants one request per cycle round-robin and drives the SRAM chip-select, write-enable, byte-enable, address and write data. It returns aligned, sign- or zero-extended read data on a per-master response channel with backpressure.

## Interface
Parameters:
- AW, 16, SRAM word-address width; byte address is AW+2 bits

Ports (mN = m0, m1; identical sets):
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- mN_req_valid  in  1  request valid
- mN_req_ready  out  1  request accepted this cycle when valid & ready
- mN_req_we  in  1  1 = store, 0 = load
- mN_req_addr  in  AW+2  byte address
- mN_req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
- mN_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- mN_req_wdata  in  32  store data, right-aligned
- mN_rsp_valid  out  1  response valid
- mN_rsp_ready  in  1  response consumed when valid & ready
- mN_rsp_rdata  out  32  load data; 0 for stores and errors
- mN_rsp_err  out  1  misaligned or illegal-size request
- sram_csn  out  1  chip select, active low
- sram_wen  out  1  write enable, active low
- sram_ben  out  4  byte enables, active high
- sram_addr  out  AW  word address = req_addr[AW+1:2]
- sram_din  out  32  write data
- sram_dout  in  32  read data for the word address latched at the last csn-low edge

## Operation
- Single pending-response slot holds: valid, owner, is_load, err, byte offset, size, unsigned.
- can_issue = !pend_valid | (pend owner's rsp_valid & rsp_ready).
- Grant is combinational:
  - When only one master is valid, that master wins.
  - When both are valid, the master pointed to by rr_ptr wins.
  - mN_req_ready = can_issue & grant==N & !rst.
- On acceptance, rr_ptr is set to the other master. The pending slot is loaded with the request attributes.
- Error check:
  - size==3 is an error.
  - size==1 with addr[0]=1 is an error.
  - size==2 with addr[1:0]!=0 is an error.
  - An erroring request never asserts sram_csn low. Its response carries err=1 and rdata=0.
- SRAM drive, for an accepted non-error request in the same cycle:
  - csn=0 and wen=!we.
  - ben = (size 0: 4'b0001, size 1: 4'b0011, size 2: 4'b1111) << addr[1:0].
  - din = wdata << 8*addr[1:0].
- In all other cycles: csn=1, wen=1, ben=0. sram_addr and sram_din are don't-care.
- Response: mN_rsp_valid = pend_valid & owner==N. The other master's rsp_valid = 0 and its rdata = 0.
- Load data is (sram_dout >> 8*offset), masked to the size and extended according to unsigned. Store responses return rdata=0.
- A pending load response is held stable indefinitely while rsp_ready=0. This relies on csn staying high: no new issue is possible, so the SRAM latched address is unchanged.
- Pending slot clears on rsp handshake unless a new request is accepted in the same cycle, in which case it is reloaded.

## Timing
- Reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, sram_csn=1, sram_wen=1, sram_ben=0, rr_ptr=0 (m0 favoured first), pend_valid=0.
- Reset asserted mid-operation clears the pending response; it is discarded, not delivered.
- Latency: request accepted in cycle T → response valid in T+1, for loads, stores and errors alike.
- Throughput: one access per cycle when the responder holds rsp_ready=1. Back-to-back grants alternate masters when both are requesting.
- While a response stalls, both req_ready are 0, and rr_ptr and the SRAM outputs hold their idle values.
- req_ready depends combinationally on req_valid of both masters and on the current rsp_ready.
- Simultaneous rsp handshake and new accept in the same cycle: the new access starts that cycle. The old read data is sampled from sram_dout that cycle, before the latched address updates.

## Test plan
- Reset, then m0 stores word 0x11223344 to addr 0x0010 → sram_csn=0, wen=0, ben=4'b1111, sram_addr=0x0004, din=0x11223344; rsp_valid next cycle with rdata=0, err=0.
- m1 loads size 0 from addr 0x0013 with unsigned=0 after the above store → sram_ben not applicable; rsp rdata=0x00000011. Repeat at addr 0x0012 with unsigned=0 after writing 0x80 to that byte → rdata=0xFFFFFF80.
- Both masters hold req_valid for 4 cycles with rsp_ready=1 → grants in order m0, m1, m0, m1, with one SRAM access per cycle.
- m0 load with m0_rsp_ready=0 for 3 cycles while m1 requests → m0 rsp_valid and rdata stay stable, m1_req_ready=0 and sram_csn=1 throughout; m1 is granted in the cycle m0_rsp_ready rises.
- m0 half store at addr 0x0021, and m1 request with size=3 → no csn-low cycle for either; each gets rsp_err=1 and rdata=0 one cycle later.
- rst pulsed while an m1 load response is pending and stalled → m1_rsp_valid drops immediately; after release, the first grant goes to m0 when both masters are requesting.
